// File: rtl/multicore_processor.sv
// SIMD accumulator processor: a single controller (PC, IR, FSM) steps CORE_COUNT
// identical datapath cores in lockstep against synchronous instruction/data memories.
module multicore_processor #(
    parameter int REG_WIDTH           = 12,
    parameter int INS_WIDTH           = 8,
    parameter int CORE_COUNT          = 3,
    parameter int DATA_MEM_ADDR_WIDTH = 12,
    parameter int INS_MEM_ADDR_WIDTH  = 8
) (
    input  logic                            clk,
    input  logic                            rstN,
    input  logic                            startN,
    input  logic [REG_WIDTH*CORE_COUNT-1:0] ProcessorDataIn,
    input  logic [INS_WIDTH-1:0]            InsMemOut,
    output logic [REG_WIDTH*CORE_COUNT-1:0] ProcessorDataOut,
    output logic [INS_MEM_ADDR_WIDTH-1:0]   insMemAddr,
    output logic [DATA_MEM_ADDR_WIDTH-1:0]  dataMemAddr,
    output logic                            DataMemWrEn,
    output logic                            done,
    output logic                            ready
);

    localparam int MASTER = CORE_COUNT - 1;

    localparam logic [3:0] S_IDLE       = 4'd0;
    localparam logic [3:0] S_FETCH      = 4'd1;
    localparam logic [3:0] S_FETCH_WAIT = 4'd2;
    localparam logic [3:0] S_EXEC       = 4'd3;
    localparam logic [3:0] S_OPND       = 4'd4;
    localparam logic [3:0] S_OPND_WAIT  = 4'd5;
    localparam logic [3:0] S_LOAD       = 4'd6;
    localparam logic [3:0] S_LOAD_WAIT  = 4'd7;
    localparam logic [3:0] S_DONE       = 4'd8;

    localparam logic [INS_WIDTH-1:0] OP_ENDOP  = 'h01;
    localparam logic [INS_WIDTH-1:0] OP_CLAC   = 'h02;
    localparam logic [INS_WIDTH-1:0] OP_LDAC   = 'h03;
    localparam logic [INS_WIDTH-1:0] OP_STAC   = 'h04;
    localparam logic [INS_WIDTH-1:0] OP_MVACAR = 'h05;
    localparam logic [INS_WIDTH-1:0] OP_MVACR  = 'h06;
    localparam logic [INS_WIDTH-1:0] OP_MVRAC  = 'h07;
    localparam logic [INS_WIDTH-1:0] OP_MVACTR = 'h08;
    localparam logic [INS_WIDTH-1:0] OP_MVTRAC = 'h09;
    localparam logic [INS_WIDTH-1:0] OP_ADD    = 'h0A;
    localparam logic [INS_WIDTH-1:0] OP_SUB    = 'h0B;
    localparam logic [INS_WIDTH-1:0] OP_MUL    = 'h0C;
    localparam logic [INS_WIDTH-1:0] OP_INCAC  = 'h0D;
    localparam logic [INS_WIDTH-1:0] OP_INCAR  = 'h0E;
    localparam logic [INS_WIDTH-1:0] OP_LDCID  = 'h0F;
    localparam logic [INS_WIDTH-1:0] OP_JUMP   = 'h10;
    localparam logic [INS_WIDTH-1:0] OP_JMPZ   = 'h11;
    localparam logic [INS_WIDTH-1:0] OP_JMPNZ  = 'h12;
    localparam logic [INS_WIDTH-1:0] OP_LDIM   = 'h13;

    logic [3:0]                    state_q, state_d;
    logic [INS_MEM_ADDR_WIDTH-1:0] pc_q, pc_d;
    logic [INS_WIDTH-1:0]          ir_q, ir_d;
    logic [REG_WIDTH-1:0]          ac_q [CORE_COUNT];
    logic [REG_WIDTH-1:0]          ac_d [CORE_COUNT];
    logic [REG_WIDTH-1:0]          r_q  [CORE_COUNT];
    logic [REG_WIDTH-1:0]          r_d  [CORE_COUNT];
    logic [REG_WIDTH-1:0]          tr_q [CORE_COUNT];
    logic [REG_WIDTH-1:0]          tr_d [CORE_COUNT];
    logic [REG_WIDTH-1:0]          ar_q [CORE_COUNT];
    logic [REG_WIDTH-1:0]          ar_d [CORE_COUNT];
    logic [CORE_COUNT-1:0]         z_q, z_d;
    logic                          acWr;

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        ir_d    = ir_q;
        ac_d    = ac_q;
        r_d     = r_q;
        tr_d    = tr_q;
        ar_d    = ar_q;
        z_d     = z_q;
        acWr    = 1'b0;
        case (state_q)
            S_IDLE, S_DONE: begin
                if (!startN) begin
                    pc_d    = '0;
                    state_d = S_FETCH;
                end
            end
            S_FETCH: state_d = S_FETCH_WAIT;
            S_FETCH_WAIT: begin
                ir_d    = InsMemOut;
                pc_d    = pc_q + 1'b1;
                state_d = S_EXEC;
            end
            S_EXEC: begin
                case (ir_q)
                    OP_ENDOP:                             state_d = S_DONE;
                    OP_LDAC:                              state_d = S_LOAD;
                    OP_JUMP, OP_JMPZ, OP_JMPNZ, OP_LDIM:  state_d = S_OPND;
                    default:                              state_d = S_FETCH;
                endcase
                for (int k = 0; k < CORE_COUNT; k++) begin
                    case (ir_q)
                        OP_CLAC:   begin ac_d[k] = '0;                   acWr = 1'b1; end
                        OP_MVACAR: ar_d[k] = ac_q[k];
                        OP_MVACR:  r_d[k]  = ac_q[k];
                        OP_MVRAC:  begin ac_d[k] = r_q[k];               acWr = 1'b1; end
                        OP_MVACTR: tr_d[k] = ac_q[k];
                        OP_MVTRAC: begin ac_d[k] = tr_q[k];              acWr = 1'b1; end
                        OP_ADD:    begin ac_d[k] = ac_q[k] + r_q[k];     acWr = 1'b1; end
                        OP_SUB:    begin ac_d[k] = ac_q[k] - r_q[k];     acWr = 1'b1; end
                        OP_MUL:    begin ac_d[k] = ac_q[k] * r_q[k];     acWr = 1'b1; end
                        OP_INCAC:  begin ac_d[k] = ac_q[k] + 1'b1;       acWr = 1'b1; end
                        OP_INCAR:  ar_d[k] = ar_q[k] + 1'b1;
                        OP_LDCID:  begin ac_d[k] = REG_WIDTH'(k);        acWr = 1'b1; end
                        default:   ;
                    endcase
                end
            end
            S_OPND: state_d = S_OPND_WAIT;
            S_OPND_WAIT: begin
                pc_d    = pc_q + 1'b1;
                state_d = S_FETCH;
                // Conditional jumps look only at the master core's Z flag.
                case (ir_q)
                    OP_JUMP:  pc_d = INS_MEM_ADDR_WIDTH'(InsMemOut);
                    OP_JMPZ:  if (z_q[MASTER])  pc_d = INS_MEM_ADDR_WIDTH'(InsMemOut);
                    OP_JMPNZ: if (!z_q[MASTER]) pc_d = INS_MEM_ADDR_WIDTH'(InsMemOut);
                    OP_LDIM: begin
                        for (int k = 0; k < CORE_COUNT; k++)
                            ac_d[k] = {{(REG_WIDTH-INS_WIDTH){1'b0}}, InsMemOut};
                        acWr = 1'b1;
                    end
                    default: ;
                endcase
            end
            S_LOAD: state_d = S_LOAD_WAIT;
            S_LOAD_WAIT: begin
                for (int k = 0; k < CORE_COUNT; k++)
                    ac_d[k] = ProcessorDataIn[(CORE_COUNT-k)*REG_WIDTH-1 -: REG_WIDTH];
                acWr    = 1'b1;
                state_d = S_FETCH;
            end
            default: state_d = S_IDLE;
        endcase
        if (acWr) begin
            for (int k = 0; k < CORE_COUNT; k++)
                z_d[k] = (ac_d[k] == '0);
        end
    end

    always_ff @(posedge clk or negedge rstN) begin
        if (!rstN) begin
            state_q <= S_IDLE;
            pc_q    <= '0;
            ir_q    <= '0;
            ac_q    <= '{default: '0};
            r_q     <= '{default: '0};
            tr_q    <= '{default: '0};
            ar_q    <= '{default: '0};
            z_q     <= '0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            ir_q    <= ir_d;
            ac_q    <= ac_d;
            r_q     <= r_d;
            tr_q    <= tr_d;
            ar_q    <= ar_d;
            z_q     <= z_d;
        end
    end

    // Core 0 occupies the most significant lane of the data word.
    always_comb begin
        ProcessorDataOut = '0;
        for (int k = 0; k < CORE_COUNT; k++)
            ProcessorDataOut[(CORE_COUNT-k)*REG_WIDTH-1 -: REG_WIDTH] = ac_q[k];
    end

    assign insMemAddr  = pc_q;
    assign dataMemAddr = ar_q[MASTER][DATA_MEM_ADDR_WIDTH-1:0];
    assign DataMemWrEn = (state_q == S_EXEC) && (ir_q == OP_STAC);
    assign done        = (state_q == S_DONE);
    assign ready       = (state_q == S_IDLE) || (state_q == S_DONE);

endmodule

// File: tb/tb_multicore_processor.sv
// Bench for multicore_processor: synchronous memory models, directed programs and
// random straight-line programs checked against an instruction-level interpreter.
module tb_multicore_processor;

    localparam int RW = 12;
    localparam int CC = 3;
    localparam int LW = RW * CC;

    logic          clk = 1'b0;
    logic          rstN, startN, we, done, ready;
    logic [LW-1:0] dataIn, dataOut;
    logic [7:0]    insOut, insAddr;
    logic [11:0]   dataAddr;

    logic [7:0]    imem    [256];
    logic [LW-1:0] dmem    [4096];
    logic [LW-1:0] initMem [4096];
    logic          loadReq = 1'b0;
    int            wrCount = 0;
    logic [7:0]    progQ [$];

    logic [RW-1:0] mAc [CC];
    logic [RW-1:0] mR  [CC];
    logic [RW-1:0] mTr [CC];
    logic [RW-1:0] mAr [CC];
    logic          mZ  [CC];
    logic [LW-1:0] mMem [4096];

    int testsRun = 0;
    int testsFailed = 0;

    always #5 clk = ~clk;

    multicore_processor dut (
        .clk(clk), .rstN(rstN), .startN(startN),
        .ProcessorDataIn(dataIn), .InsMemOut(insOut),
        .ProcessorDataOut(dataOut), .insMemAddr(insAddr), .dataMemAddr(dataAddr),
        .DataMemWrEn(we), .done(done), .ready(ready)
    );

    // Synchronous-read memories; loadReq bulk-copies the preload image into data memory.
    always @(posedge clk) begin
        insOut <= imem[insAddr];
        dataIn <= dmem[dataAddr];
        if (loadReq) begin
            for (int a = 0; a < 4096; a++) dmem[a] <= initMem[a];
        end else if (we) begin
            dmem[dataAddr] <= dataOut;
            wrCount <= wrCount + 1;
        end
    end

    task automatic modelClear();
        for (int k = 0; k < CC; k++) begin
            mAc[k] = '0; mR[k] = '0; mTr[k] = '0; mAr[k] = '0; mZ[k] = 1'b0;
        end
    endtask

    task automatic doReset();
        @(negedge clk);
        rstN = 1'b0; startN = 1'b1;
        repeat (3) @(negedge clk);
        rstN = 1'b1;
        modelClear();
        @(negedge clk);
    endtask

    task automatic pushMem();
        @(negedge clk) loadReq = 1'b1;
        @(negedge clk) loadReq = 1'b0;
    endtask

    task automatic clearInit();
        for (int a = 0; a < 4096; a++) initMem[a] = '0;
    endtask

    task automatic loadProg();
        for (int i = 0; i < 256; i++) imem[i] = 8'h01;
        for (int i = 0; i < progQ.size(); i++) imem[i] = progQ[i];
    endtask

    task automatic startRun();
        @(negedge clk) startN = 1'b0;
        @(negedge clk) startN = 1'b1;
    endtask

    task automatic waitDone(input int budget, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < budget && !ok; i++) begin
            @(negedge clk);
            if (done) ok = 1'b1;
        end
    endtask

    // Instruction-level interpreter of the ISA working on whole data words.
    task automatic modelRun(output int writes, output bit finished);
        logic [7:0]    pc, op, n;
        logic [2*RW-1:0] prod;
        logic [LW-1:0] word;
        bit            acChanged;
        int            steps;
        writes = 0; finished = 1'b0; pc = 8'h00; steps = 0;
        while (!finished && steps < 2000) begin
            steps++;
            op = imem[pc]; pc = pc + 8'd1; n = 8'h00; acChanged = 1'b0;
            if (op >= 8'h10 && op <= 8'h13) begin
                n = imem[pc]; pc = pc + 8'd1;
            end
            case (op)
                8'h01: finished = 1'b1;
                8'h03: begin
                    word = mMem[mAr[CC-1]];
                    for (int k = 0; k < CC; k++) mAc[k] = RW'(word >> ((CC-1-k)*RW));
                    acChanged = 1'b1;
                end
                8'h04: begin
                    word = '0;
                    for (int k = 0; k < CC; k++) word = (word << RW) | LW'(mAc[k]);
                    mMem[mAr[CC-1]] = word;
                    writes++;
                end
                8'h10: pc = n;
                8'h11: if (mZ[CC-1]) pc = n;
                8'h12: if (!mZ[CC-1]) pc = n;
                default: ;
            endcase
            for (int k = 0; k < CC; k++) begin
                case (op)
                    8'h02: begin mAc[k] = 0; acChanged = 1'b1; end
                    8'h05: mAr[k] = mAc[k];
                    8'h06: mR[k] = mAc[k];
                    8'h07: begin mAc[k] = mR[k]; acChanged = 1'b1; end
                    8'h08: mTr[k] = mAc[k];
                    8'h09: begin mAc[k] = mTr[k]; acChanged = 1'b1; end
                    8'h0A: begin mAc[k] = RW'((int'(mAc[k]) + int'(mR[k])) % 4096); acChanged = 1'b1; end
                    8'h0B: begin mAc[k] = RW'((int'(mAc[k]) - int'(mR[k]) + 4096) % 4096); acChanged = 1'b1; end
                    8'h0C: begin prod = mAc[k] * mR[k]; mAc[k] = prod[RW-1:0]; acChanged = 1'b1; end
                    8'h0D: begin mAc[k] = RW'((int'(mAc[k]) + 1) % 4096); acChanged = 1'b1; end
                    8'h0E: mAr[k] = RW'((int'(mAr[k]) + 1) % 4096);
                    8'h0F: begin mAc[k] = RW'(k); acChanged = 1'b1; end
                    8'h13: begin mAc[k] = RW'(n); acChanged = 1'b1; end
                    default: ;
                endcase
                if (acChanged) mZ[k] = (mAc[k] == 0);
            end
        end
    endtask

    task automatic test_reset();
        rstN = 1'b0; startN = 1'b1;
        @(negedge clk);
        testsRun++; if (ready !== 1'b1) begin testsFailed++; $display("[TB] FAIL reset_ready: got %b expected 1", ready); end
        testsRun++; if (done !== 1'b0) begin testsFailed++; $display("[TB] FAIL reset_done: got %b expected 0", done); end
        testsRun++; if (we !== 1'b0) begin testsFailed++; $display("[TB] FAIL reset_wren: got %b expected 0", we); end
        testsRun++; if (insAddr !== 8'h00) begin testsFailed++; $display("[TB] FAIL reset_insaddr: got %h expected 00", insAddr); end
        testsRun++; if (dataAddr !== 12'h000) begin testsFailed++; $display("[TB] FAIL reset_dataaddr: got %h expected 000", dataAddr); end
        testsRun++; if (dataOut !== '0) begin testsFailed++; $display("[TB] FAIL reset_dataout: got %h expected 0", dataOut); end
        rstN = 1'b1;
    endtask

    task automatic test_reset_midrun();
        int base;
        progQ = '{8'h13, 8'h05, 8'h05, 8'h04, 8'h01};
        loadProg();
        doReset();
        base = wrCount;
        startRun();
        repeat (4) @(negedge clk);
        rstN = 1'b0;
        #1;
        testsRun++; if (ready !== 1'b1 || insAddr !== 8'h00) begin testsFailed++; $display("[TB] FAIL midreset_abort: got ready=%b addr=%h expected ready=1 addr=00", ready, insAddr); end
        repeat (15) @(negedge clk);
        rstN = 1'b1;
        @(negedge clk);
        testsRun++; if (wrCount !== base) begin testsFailed++; $display("[TB] FAIL midreset_nowrite: got %0d writes expected 0", wrCount - base); end
        testsRun++; if (done !== 1'b0) begin testsFailed++; $display("[TB] FAIL midreset_done: got %b expected 0", done); end
    endtask

    task automatic test_load_inc_store();
        bit ok; int base;
        doReset();
        clearInit(); initMem[7] = 36'h00A00B00C; pushMem();
        progQ = '{8'h13, 8'h07, 8'h05, 8'h03, 8'h0D, 8'h04, 8'h01};
        loadProg();
        base = wrCount;
        startRun();
        waitDone(500, ok);
        testsRun++; if (!ok) begin testsFailed++; $display("[TB] FAIL lis_timeout: got done=0 expected done=1"); end
        testsRun++; if (wrCount - base !== 1) begin testsFailed++; $display("[TB] FAIL lis_writes: got %0d expected 1", wrCount - base); end
        testsRun++; if (dmem[7] !== 36'h00B00C00D) begin testsFailed++; $display("[TB] FAIL lis_mem7: got %h expected 00b00c00d", dmem[7]); end
        testsRun++; if (dataAddr !== 12'h007) begin testsFailed++; $display("[TB] FAIL lis_addr: got %h expected 007", dataAddr); end
        repeat (5) @(negedge clk);
        testsRun++; if (done !== 1'b1 || ready !== 1'b1) begin testsFailed++; $display("[TB] FAIL lis_done_held: got done=%b ready=%b expected 1 1", done, ready); end
    endtask

    task automatic test_core_id();
        bit ok; int base;
        doReset();
        clearInit(); pushMem();
        progQ = '{8'h13, 8'h09, 8'h05, 8'h0F, 8'h04, 8'h01};
        loadProg();
        base = wrCount;
        startRun();
        waitDone(500, ok);
        testsRun++; if (!ok) begin testsFailed++; $display("[TB] FAIL cid_timeout: got done=0 expected done=1"); end
        testsRun++; if (dmem[9] !== 36'h000001002) begin testsFailed++; $display("[TB] FAIL cid_mem9: got %h expected 000001002", dmem[9]); end
        testsRun++; if (wrCount - base !== 1) begin testsFailed++; $display("[TB] FAIL cid_writes: got %0d expected 1", wrCount - base); end
    endtask

    task automatic test_wrap();
        bit ok; int base;
        doReset();
        clearInit(); pushMem();
        progQ = '{8'h13, 8'h20, 8'h05, 8'h13, 8'h80, 8'h06, 8'h13, 8'h10, 8'h0C, 8'h08,
                  8'h13, 8'h02, 8'h06, 8'h09, 8'h0C, 8'h11, 8'h14, 8'h04, 8'h01, 8'h00,
                  8'h13, 8'h01, 8'h06, 8'h02, 8'h0B, 8'h04, 8'h0D, 8'h11, 8'h1E, 8'h01,
                  8'h13, 8'h21, 8'h05, 8'h13, 8'h5A, 8'h04, 8'h01};
        loadProg();
        base = wrCount;
        startRun();
        waitDone(1000, ok);
        testsRun++; if (!ok) begin testsFailed++; $display("[TB] FAIL wrap_timeout: got done=0 expected done=1"); end
        testsRun++; if (dmem[32] !== 36'hFFFFFFFFF) begin testsFailed++; $display("[TB] FAIL wrap_sub: got %h expected fffffffff", dmem[32]); end
        testsRun++; if (dmem[33] !== 36'h05A05A05A) begin testsFailed++; $display("[TB] FAIL wrap_zpath: got %h expected 05a05a05a", dmem[33]); end
        testsRun++; if (wrCount - base !== 2) begin testsFailed++; $display("[TB] FAIL wrap_writes: got %0d expected 2", wrCount - base); end
    endtask

    task automatic test_loop();
        bit ok; int base;
        doReset();
        clearInit(); pushMem();
        progQ = '{8'h13, 8'h40, 8'h05, 8'h13, 8'h01, 8'h06, 8'h13, 8'h03,
                  8'h0B, 8'h0E, 8'h04, 8'h12, 8'h08, 8'h01};
        loadProg();
        base = wrCount;
        startRun();
        waitDone(1000, ok);
        testsRun++; if (!ok) begin testsFailed++; $display("[TB] FAIL loop_timeout: got done=0 expected done=1"); end
        testsRun++; if (wrCount - base !== 3) begin testsFailed++; $display("[TB] FAIL loop_iters: got %0d expected 3", wrCount - base); end
        testsRun++; if (dmem[65] !== 36'h002002002) begin testsFailed++; $display("[TB] FAIL loop_it1: got %h expected 002002002", dmem[65]); end
        testsRun++; if (dmem[66] !== 36'h001001001) begin testsFailed++; $display("[TB] FAIL loop_it2: got %h expected 001001001", dmem[66]); end
        testsRun++; if (dmem[67] !== 36'h000000000) begin testsFailed++; $display("[TB] FAIL loop_it3: got %h expected 000000000", dmem[67]); end
        testsRun++; if (dataOut !== '0) begin testsFailed++; $display("[TB] FAIL loop_final_ac: got %h expected 0", dataOut); end
    endtask

    task automatic test_restart();
        bit ok;
        testsRun++; if (done !== 1'b1) begin testsFailed++; $display("[TB] FAIL restart_pre_done: got %b expected 1", done); end
        startRun();
        testsRun++; if (done !== 1'b0 || ready !== 1'b0) begin testsFailed++; $display("[TB] FAIL restart_busy: got done=%b ready=%b expected 0 0", done, ready); end
        testsRun++; if (insAddr !== 8'h00) begin testsFailed++; $display("[TB] FAIL restart_pc: got %h expected 00", insAddr); end
        waitDone(1000, ok);
        testsRun++; if (!ok) begin testsFailed++; $display("[TB] FAIL restart_done: got done=0 expected done=1"); end
    endtask

    task automatic test_random_programs();
        bit ok, mFin; int base, mWrites, bad, firstBad;
        logic [7:0] pool [16] = '{8'h00, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06, 8'h07, 8'h08,
                                  8'h09, 8'h0A, 8'h0B, 8'h0C, 8'h0D, 8'h0E, 8'h0F, 8'h13};
        logic [LW-1:0] expOut;
        int idx;
        for (int iter = 0; iter < 5; iter++) begin
            doReset();
            for (int a = 0; a < 4096; a++) begin
                initMem[a] = {4'($urandom_range(0, 15)), 32'($urandom())};
                mMem[a] = initMem[a];
            end
            pushMem();
            progQ.delete();
            for (int i = 0; i < 14; i++) begin
                idx = $urandom_range(0, 16);
                if (idx == 16) progQ.push_back(8'h80 | 8'($urandom_range(0, 127)));
                else begin
                    progQ.push_back(pool[idx]);
                    if (pool[idx] == 8'h13) progQ.push_back(8'($urandom_range(0, 255)));
                end
            end
            progQ.push_back(8'h01);
            loadProg();
            base = wrCount;
            startRun();
            for (int c = 0; c < 8; c++) begin
                @(negedge clk) startN = 1'($urandom_range(0, 1));
            end
            startN = 1'b1;
            waitDone(2000, ok);
            modelRun(mWrites, mFin);
            expOut = '0;
            for (int k = 0; k < CC; k++) expOut = (expOut << RW) | LW'(mAc[k]);
            bad = 0; firstBad = -1;
            for (int a = 0; a < 4096; a++) begin
                if (dmem[a] !== mMem[a]) begin
                    bad++;
                    if (firstBad < 0) firstBad = a;
                end
            end
            testsRun++; if (!ok || !mFin) begin testsFailed++; $display("[TB] FAIL rand%0d_done: got done=%b expected 1", iter, ok); end
            testsRun++; if (wrCount - base !== mWrites) begin testsFailed++; $display("[TB] FAIL rand%0d_writes: got %0d expected %0d", iter, wrCount - base, mWrites); end
            testsRun++; if (dataOut !== expOut) begin testsFailed++; $display("[TB] FAIL rand%0d_acs: got %h expected %h", iter, dataOut, expOut); end
            testsRun++; if (dataAddr !== mAr[CC-1]) begin testsFailed++; $display("[TB] FAIL rand%0d_ar: got %h expected %h", iter, dataAddr, mAr[CC-1]); end
            testsRun++; if (bad != 0) begin testsFailed++; $display("[TB] FAIL rand%0d_mem: got %0d differing words (first at %0d) expected 0", iter, bad, firstBad); end
        end
    endtask

    initial begin
        rstN = 1'b0;
        startN = 1'b1;
        for (int i = 0; i < 256; i++) imem[i] = 8'h01;
        test_reset();
        test_reset_midrun();
        test_load_inc_store();
        test_core_id();
        test_wrap();
        test_loop();
        test_restart();
        test_random_programs();
        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end

endmodule
